plab5_mcore_mem_resp_net_serializer: RTL and testbench
======================================================

PLAB5_MCORE_MEM_RESP_NET_SERIALIZER -- requirements
Module: plab5_mcore_mem_resp_net_serializer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): p_net_src, 0, source bank id; p_num_ports, 4, cores/banks; p_mem_opaque_nbits (mo), 8, memory opaque width; p_mem_data_nbits (md), 32, word width; p_net_opaque_nbits (no), 4, network opaque width; p_net_srcdest_nbits (ns), 3, src/dest width; p_cacheline_nwords (nw), 4, words per line.
REQ-002 Elaboration SHALL require no >= clog2(nw), ns <= mo, and nw a power of two >= 2.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- domain  in  1  security domain of the offered response, sampled on accept
- mem_resp_val  in  1  response valid
- mem_resp_rdy  out  1  response ready
- mem_resp_control  in  VC_MEM_RESP_MSG_NBITS(mo,md)-md  {type, opaque, len}
- mem_resp_data  in  nw*md  line data; word k at bits [k*md +: md]
- mem_resp_line  in  1  1 = full-line response, 0 = single word (word 0)
- mem_resp_fail  in  1  access denied by the protection check
- net_msg_val  out  1  flit valid
- net_msg_rdy  in  1  network ready
- net_msg_control  out  VC_NET_MSG_NBITS(npc+2,no,ns)  {dest, src, opaque, payload}
- net_msg_data  out  md  flit data word

Function
REQ-005 Handshakes SHALL be val/rdy; a transfer occurs on a rising edge with val and rdy both high.
REQ-006 The FSM SHALL have states IDLE and SEND; mem_resp_rdy = (state == IDLE); net_msg_val = (state == SEND).
REQ-007 IDLE -> SEND on input transfer: register control, data, domain, fail and flit count (1 if mem_resp_line=0 or mem_resp_fail=1, else nw); word index cleared to 0.
REQ-008 The first flit SHALL be valid the cycle after input acceptance (latency 1).
REQ-009 In SEND, each output transfer SHALL increment the word index; the transfer of the last flit SHALL return the FSM to IDLE, so mem_resp_rdy rises the following cycle (one bubble between responses).
REQ-010 With net_msg_rdy low, all outputs SHALL hold stable and the word index SHALL NOT change.
REQ-011 net_msg_control dest SHALL be opaque[mo-1 -: ns] of the registered response; src SHALL be p_net_src[ns-1:0]; opaque SHALL be the word index zero-extended to no bits.
REQ-012 Payload SHALL be {domain, fail, type, opaque, len} (npc+2 bits), identical in every flit of a response.
REQ-013 net_msg_data SHALL be registered word[index]; words SHALL be emitted in ascending order 0..nw-1.
REQ-014 If registered fail = 1, exactly one flit SHALL be sent, with net_msg_data = 0, regardless of mem_resp_line.
REQ-015 In IDLE, net_msg_data and net_msg_control SHALL be driven to 0 (no stale data from a previous domain).
REQ-016 The word index SHALL be clog2(nw) bits and SHALL NOT wrap within a response; the last flit is index = count-1.
REQ-017 mem_resp_val asserted in SEND SHALL be ignored (not accepted) until IDLE.

Reset
REQ-018 On reset low, asynchronously: state = IDLE, word index = 0, all data/control/domain/fail registers = 0; hence mem_resp_rdy = 1 (after release), net_msg_val = 0, net_msg_data = 0, net_msg_control = 0.
REQ-019 Reset asserted mid-response SHALL discard the in-flight response; no further flits of it SHALL appear after reset release.

Verification
REQ-020 Line read: defaults, p_net_src=2, opaque=8'hA3, line=1, fail=0, data words 11,22,33,44, net_msg_rdy=1 -> 4 flits on consecutive cycles starting 1 cycle after accept, dest=5, src=2, net opaque 0..3, data 11,22,33,44; mem_resp_rdy high again 1 cycle after last flit.
REQ-021 Single word: line=0, word0=0xDEADBEEF, domain=1 -> exactly 1 flit, data 0xDEADBEEF, payload MSB (domain)=1, net opaque 0.
REQ-022 Fail: line=1, fail=1, nonzero data -> exactly 1 flit, data 0, payload fail bit=1.
REQ-023 Back-pressure: line read, net_msg_rdy low for 3 cycles after flit 1 -> flit 1 held stable 3 cycles, then flits 1..3 in order, no drop or duplicate; mem_resp_val held high during SEND not accepted.
REQ-024 Reset mid-burst: reset low after flit 1 of a line read -> net_msg_val=0, net_msg_data=0 immediately; after release mem_resp_rdy=1 and no flits until a new response is accepted.

Source files
------------

// File: rtl/plab5_mcore_mem_resp_net_serializer.sv
// Memory-response to network serializer: accepts one memory response (single
// word or full cache line) and emits it as one network flit per data word.
module plab5_mcore_mem_resp_net_serializer #(
  parameter int unsigned p_net_src           = 0,
  parameter int unsigned p_num_ports         = 4,
  parameter int unsigned p_mem_opaque_nbits  = 8,
  parameter int unsigned p_mem_data_nbits    = 32,
  parameter int unsigned p_net_opaque_nbits  = 4,
  parameter int unsigned p_net_srcdest_nbits = 3,
  parameter int unsigned p_cacheline_nwords  = 4,
  localparam int unsigned LenW  = $clog2(p_mem_data_nbits / 8),
  localparam int unsigned CtrlW = 3 + p_mem_opaque_nbits + LenW,
  localparam int unsigned PayW  = CtrlW + 2,
  localparam int unsigned NetW  = PayW + p_net_opaque_nbits + 2 * p_net_srcdest_nbits
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         domain,
  input  logic                                         mem_resp_val,
  output logic                                         mem_resp_rdy,
  input  logic [CtrlW-1:0]                             mem_resp_control,
  input  logic [p_cacheline_nwords*p_mem_data_nbits-1:0] mem_resp_data,
  input  logic                                         mem_resp_line,
  input  logic                                         mem_resp_fail,
  output logic                                         net_msg_val,
  input  logic                                         net_msg_rdy,
  output logic [NetW-1:0]                              net_msg_control,
  output logic [p_mem_data_nbits-1:0]                  net_msg_data
);

  localparam int unsigned MO   = p_mem_opaque_nbits;
  localparam int unsigned MD   = p_mem_data_nbits;
  localparam int unsigned NO   = p_net_opaque_nbits;
  localparam int unsigned NS   = p_net_srcdest_nbits;
  localparam int unsigned NW   = p_cacheline_nwords;
  localparam int unsigned IdxW = $clog2(NW);

  // Reject configurations the flit format cannot represent
  if (NO < IdxW || NS > MO || NW < 2 || (NW & (NW - 1)) != 0 ||
      p_net_src >= p_num_ports) begin : g_bad_cfg
    $error("plab5_mcore_mem_resp_net_serializer: illegal parameter set");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q;
  logic [IdxW-1:0]  last_q;
  logic [CtrlW-1:0] ctrl_q;
  logic             dom_q;
  logic             fail_q;
  logic [MD-1:0]    words_q [NW];

  logic accept;
  logic send_xfer;
  logic last_flit;

  assign accept    = (state_q == ST_IDLE) && mem_resp_val;
  assign send_xfer = (state_q == ST_SEND) && net_msg_rdy;
  assign last_flit = (idx_q == last_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mem_resp_val)           state_d = ST_SEND;
      ST_SEND: if (net_msg_rdy && last_flit) state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Capture the response on accept and step the word index per sent flit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      last_q <= '0;
      ctrl_q <= '0;
      dom_q  <= 1'b0;
      fail_q <= 1'b0;
      for (int k = 0; k < int'(NW); k++) words_q[k] <= '0;
    end else if (accept) begin
      idx_q  <= '0;
      last_q <= (mem_resp_line && !mem_resp_fail) ? IdxW'(NW - 1) : '0;
      ctrl_q <= mem_resp_control;
      dom_q  <= domain;
      fail_q <= mem_resp_fail;
      for (int k = 0; k < int'(NW); k++) words_q[k] <= mem_resp_data[k*MD +: MD];
    end else if (send_xfer && !last_flit) begin
      idx_q <= idx_q + IdxW'(1);
    end
  end

  // Outputs: handshakes from state, flit fields zeroed while idle
  always_comb begin
    mem_resp_rdy    = 1'b0;
    net_msg_val     = 1'b0;
    net_msg_control = '0;
    net_msg_data    = '0;
    if (state_q == ST_IDLE) begin
      mem_resp_rdy = 1'b1;
    end else begin
      net_msg_val     = 1'b1;
      net_msg_control = {ctrl_q[LenW+MO-1 -: NS], NS'(p_net_src), NO'(idx_q),
                         dom_q, fail_q, ctrl_q};
      net_msg_data    = fail_q ? '0 : words_q[idx_q];
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_resp_net_serializer.sv
// Scoreboard bench for the memory-response network serializer.
module tb_plab5_mcore_mem_resp_net_serializer;

  localparam int unsigned CW  = 13;
  localparam int unsigned NCW = 25;

  typedef struct packed {
    logic [NCW-1:0] ctrl;
    logic [31:0]    data;
  } flit_t;

  logic           clk;
  logic           reset;
  logic           domain;
  logic           mem_resp_val;
  logic           mem_resp_rdy;
  logic [CW-1:0]  mem_resp_control;
  logic [127:0]   mem_resp_data;
  logic           mem_resp_line;
  logic           mem_resp_fail;
  logic           net_msg_val;
  logic           net_msg_rdy;
  logic [NCW-1:0] net_msg_control;
  logic [31:0]    net_msg_data;

  flit_t sb_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  plab5_mcore_mem_resp_net_serializer #(.p_net_src(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .domain           (domain),
    .mem_resp_val     (mem_resp_val),
    .mem_resp_rdy     (mem_resp_rdy),
    .mem_resp_control (mem_resp_control),
    .mem_resp_data    (mem_resp_data),
    .mem_resp_line    (mem_resp_line),
    .mem_resp_fail    (mem_resp_fail),
    .net_msg_val      (net_msg_val),
    .net_msg_rdy      (net_msg_rdy),
    .net_msg_control  (net_msg_control),
    .net_msg_data     (net_msg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected network control word; source id is fixed at 2 for this bench
  function automatic logic [NCW-1:0] mk(input logic [2:0] dest, input logic [3:0] opq,
                                        input logic dom, input logic fail,
                                        input logic [CW-1:0] rc);
    return {dest, 3'd2, opq, dom, fail, rc};
  endfunction

  function automatic flit_t fl(input logic [NCW-1:0] c, input logic [31:0] d);
    flit_t f;
    f.ctrl = c;
    f.data = d;
    return f;
  endfunction

  // Monitor: every flit transfer must match the head of the scoreboard
  initial begin
    flit_t e;
    forever begin
      @(negedge clk);
      if (reset && net_msg_val && net_msg_rdy) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_flit: got ctrl %h data %h, none expected",
                   net_msg_control, net_msg_data);
        end else begin
          e = sb_q.pop_front();
          check("flit_ctrl", 64'(net_msg_control), 64'(e.ctrl));
          check("flit_data", 64'(net_msg_data), 64'(e.data));
        end
      end
    end
  end

  // Offer one response; returns just after the accepting edge
  task automatic offer(input logic [CW-1:0] rc, input logic [127:0] d,
                       input logic line, input logic fail, input logic dom);
    mem_resp_control = rc;
    mem_resp_data    = d;
    mem_resp_line    = line;
    mem_resp_fail    = fail;
    domain           = dom;
    mem_resp_val     = 1'b1;
    @(negedge clk);
    check("accept_rdy", 64'(mem_resp_rdy), 64'd1);
    @(posedge clk);
    #1;
    mem_resp_val = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then expect an idle, ready block
  task automatic drain(input int exp_cyc);
    int cyc = 0;
    while (sb_q.size() != 0 && cyc < 30) begin
      @(negedge clk);
      #1;
      cyc++;
      if (cyc == 1 && exp_cyc > 0) check("first_flit_latency", 64'(net_msg_val), 64'd1);
    end
    check("drain_left", 64'(sb_q.size()), 64'd0);
    if (exp_cyc > 0) check("flit_cycles", 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    check("idle_rdy", 64'(mem_resp_rdy), 64'd1);
    check("idle_val", 64'(net_msg_val), 64'd0);
  endtask

  logic [CW-1:0] rc;

  initial begin
    reset            = 1'b0;
    domain           = 1'b0;
    mem_resp_val     = 1'b0;
    mem_resp_control = '0;
    mem_resp_data    = '0;
    mem_resp_line    = 1'b0;
    mem_resp_fail    = 1'b0;
    net_msg_rdy      = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_val", 64'(net_msg_val), 64'd0);
    check("rst_data", 64'(net_msg_data), 64'd0);
    check("rst_ctrl", 64'(net_msg_control), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_rdy", 64'(mem_resp_rdy), 64'd1);
    @(posedge clk);
    #1;

    // Line read: dest = 0xA3[7:5] = 5, words 11,22,33,44
    rc = {3'd0, 8'hA3, 2'd0};
    for (int k = 0; k < 4; k++)
      sb_q.push_back(fl(mk(3'd5, 4'(k), 1'b0, 1'b0, rc), 32'(11 * (k + 1))));
    offer(rc, {32'd44, 32'd33, 32'd22, 32'd11}, 1'b1, 1'b0, 1'b0);
    drain(4);

    // Single word, domain 1: dest = 0x47[7:5] = 2
    @(posedge clk);
    #1;
    rc = {3'd0, 8'h47, 2'd0};
    sb_q.push_back(fl(mk(3'd2, 4'd0, 1'b1, 1'b0, rc), 32'hDEADBEEF));
    offer(rc, {32'h1, 32'h2, 32'h3, 32'hDEADBEEF}, 1'b0, 1'b0, 1'b1);
    drain(1);

    // Fail on a line request: one flit, zero data, dest = 0xE1[7:5] = 7
    @(posedge clk);
    #1;
    rc = {3'd0, 8'hE1, 2'd0};
    sb_q.push_back(fl(mk(3'd7, 4'd0, 1'b0, 1'b1, rc), 32'h0));
    offer(rc, {32'hA, 32'hB, 32'hC, 32'hD}, 1'b1, 1'b1, 1'b0);
    drain(1);

    // Back-pressure after flit 0; a pending request must not be accepted
    @(posedge clk);
    #1;
    rc = {3'd1, 8'h3C, 2'd3};
    for (int k = 0; k < 4; k++)
      sb_q.push_back(fl(mk(3'd1, 4'(k), 1'b1, 1'b0, rc), 32'h55 + 32'(k * 17)));
    offer(rc, {32'h88, 32'h77, 32'h66, 32'h55}, 1'b1, 1'b0, 1'b1);
    mem_resp_control = {3'd0, 8'hFF, 2'd0};
    mem_resp_data    = '1;
    mem_resp_line    = 1'b1;
    mem_resp_val     = 1'b1;
    @(posedge clk);
    #1;
    net_msg_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_val", 64'(net_msg_val), 64'd1);
      check("stall_data", 64'(net_msg_data), 64'h66);
      check("stall_ctrl", 64'(net_msg_control), 64'(mk(3'd1, 4'd1, 1'b1, 1'b0, rc)));
      check("stall_no_accept", 64'(mem_resp_rdy), 64'd0);
    end
    @(posedge clk);
    #1;
    net_msg_rdy  = 1'b1;
    mem_resp_val = 1'b0;
    drain(-1);
    repeat (3) @(negedge clk);

    // Reset in the middle of a line read
    @(posedge clk);
    #1;
    rc = {3'd0, 8'h80, 2'd0};
    for (int k = 0; k < 4; k++)
      sb_q.push_back(fl(mk(3'd4, 4'(k), 1'b0, 1'b0, rc), 32'h100 + 32'(k)));
    offer(rc, {32'h103, 32'h102, 32'h101, 32'h100}, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_val", 64'(net_msg_val), 64'd0);
    check("midrst_data", 64'(net_msg_data), 64'd0);
    check("midrst_ctrl", 64'(net_msg_control), 64'd0);
    check("midrst_sent", 64'(sb_q.size()), 64'd3);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_val", 64'(net_msg_val), 64'd0);
      check("postrst_rdy", 64'(mem_resp_rdy), 64'd1);
    end

    // Normal operation after reset: single word, dest = 0x20[7:5] = 1
    @(posedge clk);
    #1;
    rc = {3'd0, 8'h20, 2'd0};
    sb_q.push_back(fl(mk(3'd1, 4'd0, 1'b0, 1'b0, rc), 32'h12345678));
    offer(rc, {32'h9, 32'h8, 32'h7, 32'h12345678}, 1'b0, 1'b0, 1'b0);
    drain(1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
